iir_out_checker: RTL and testbench

- Synthesizable output-side capture and checker for the IIR filter datapath.
- Consumes the filter's Q2.22 output stream (data_in/data_in_valid) once the filter reports stable.
- Writes each accepted sample into a capture RAM and compares it against a golden reference ROM.
- Reports error count, maximum absolute difference, timeout and pass/fail, so the on-chip self-test runs without a simulator.

---
 rtl/iir_out_checker_if.sv | 24 ++
 rtl/iir_out_checker.sv | 150 +++++++++++++++
 tb/tb_iir_out_checker.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/iir_out_checker_if.sv
// Stream, reference-ROM and capture-RAM signals of the IIR output checker.
// master = checker side, slave = filter/memory side.
interface iir_out_checker_if #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 11
);
    logic [DATA_W-1:0] data_in;
    logic              data_in_valid;
    logic [ADDR_W-1:0] ref_addr;
    logic [DATA_W-1:0] ref_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        input  data_in, data_in_valid, ref_data,
        output ref_addr, wr_en, wr_addr, wr_data
    );

    modport slave (
        output data_in, data_in_valid, ref_data,
        input  ref_addr, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/iir_out_checker.sv
// Captures the filter output stream into RAM and checks it against a
// golden ROM, reporting mismatch count, max |error|, timeout and pass.
module iir_out_checker #(
    parameter int DATA_W  = 24,
    parameter int N       = 2048,
    parameter int ADDR_W  = 11,
    parameter int TIMEOUT = 2000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stable_in,
    iir_out_checker_if.master   bus,
    output logic                busy,
    output logic                done,
    output logic                timeout,
    output logic [ADDR_W:0]     err_cnt,
    output logic [DATA_W:0]     max_err,
    output logic                pass
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, ARM, CAPTURE, DRAIN, DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              s1_vld_q, s1_vld_d;
    logic [DATA_W-1:0] s1_data_q, s1_data_d;
    logic [ADDR_W:0]   err_q, err_d;
    logic [DATA_W:0]   max_q, max_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tflag_q, tflag_d;

    logic                     accept;
    logic                     run;
    logic signed [DATA_W:0]   diff;
    logic        [DATA_W:0]   absd;

    assign accept = (state_q == CAPTURE) && bus.data_in_valid;
    assign run    = (state_q == ARM) || (state_q == CAPTURE)
                 || (state_q == DRAIN);

    assign bus.wr_en    = accept;
    assign bus.wr_addr  = cnt_q;
    assign bus.wr_data  = bus.data_in;
    assign bus.ref_addr = (state_q == CAPTURE) ? cnt_q : '0;

    // One extra bit keeps full-scale opposite-sign differences exact.
    assign diff = $signed({s1_data_q[DATA_W-1], s1_data_q})
                - $signed({bus.ref_data[DATA_W-1], bus.ref_data});
    assign absd = diff[DATA_W] ? $unsigned(-diff) : $unsigned(diff);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tmo_d     = run ? tmo_q + TW'(1) : tmo_q;
        s1_vld_d  = accept;
        s1_data_d = accept ? bus.data_in : s1_data_q;
        err_d     = err_q;
        max_d     = max_q;
        busy_d    = busy_q;
        done_d    = done_q;
        tflag_d   = tflag_q;

        if (s1_vld_q) begin
            if (diff != '0 && err_q != {(ADDR_W+1){1'b1}})
                err_d = err_q + 1'b1;
            if (absd > max_q)
                max_d = absd;
        end

        if (accept)
            cnt_d = cnt_q + 1'b1;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = ARM;
                    cnt_d    = '0;
                    tmo_d    = '0;
                    s1_vld_d = 1'b0;
                    err_d    = '0;
                    max_d    = '0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    tflag_d  = 1'b0;
                end
            end
            ARM: begin
                if (stable_in)
                    state_d = CAPTURE;
            end
            CAPTURE: begin
                if (accept && cnt_q == ADDR_W'(N - 1))
                    state_d = DRAIN;
            end
            DRAIN: begin
                state_d = DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Watchdog overrides normal sequencing; pending compare still lands.
        if (run && tmo_q == TW'(TIMEOUT - 1)) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            tflag_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            tmo_q     <= '0;
            s1_vld_q  <= 1'b0;
            s1_data_q <= '0;
            err_q     <= '0;
            max_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            tflag_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            s1_vld_q  <= s1_vld_d;
            s1_data_q <= s1_data_d;
            err_q     <= err_d;
            max_q     <= max_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            tflag_q   <= tflag_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign timeout = tflag_q;
    assign err_cnt = err_q;
    assign max_err = max_q;
    assign pass    = done_q & ~tflag_q & (err_q == '0);
endmodule

// File: tb/tb_iir_out_checker.sv
// Scoreboard bench: stimulus queues expected RAM writes and run results,
// a forked monitor pops and compares whenever the DUT presents them.
module tb_iir_out_checker;
    localparam int DW  = 24;
    localparam int AW  = 11;
    localparam int NS  = 2048;
    localparam int TMO = 5000;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stable_in;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [AW:0]   err_cnt;
    logic [DW:0]   max_err;
    logic          pass;

    always #5 clk = ~clk;

    iir_out_checker_if #(.DATA_W(DW), .ADDR_W(AW)) ifc ();

    iir_out_checker #(
        .DATA_W(DW), .N(NS), .ADDR_W(AW), .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .stable_in(stable_in),
        .bus(ifc),
        .busy(busy),
        .done(done),
        .timeout(timeout),
        .err_cnt(err_cnt),
        .max_err(max_err),
        .pass(pass)
    );

    logic [DW-1:0] samp_mem [NS];
    logic [DW-1:0] ref_mem  [NS];

    // Synchronous golden ROM: data one cycle after address.
    always @(posedge clk) ifc.ref_data <= ref_mem[ifc.ref_addr];

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        logic [AW:0] err;
        logic [DW:0] mx;
        logic        ps;
        logic        tmo;
    } res_t;

    wr_t  wr_q  [$];
    res_t res_q [$];

    int checks   = 0;
    int failures = 0;

    function automatic void chk(string name, logic [63:0] act,
                                logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    task automatic monitor();
        logic done_d;
        wr_t  w;
        res_t r;
        done_d = 1'b0;
        forever begin
            @(negedge clk);
            if (ifc.wr_en === 1'b1) begin
                if (wr_q.size() == 0) begin
                    chk("wr_unexpected", ifc.wr_en, 0);
                end else begin
                    w = wr_q.pop_front();
                    chk("wr_addr", ifc.wr_addr, w.addr);
                    chk("wr_data", ifc.wr_data, w.data);
                end
            end
            if (done === 1'b1 && !done_d) begin
                if (res_q.size() == 0) begin
                    chk("done_unexpected", done, 0);
                end else begin
                    r = res_q.pop_front();
                    chk("err_cnt", err_cnt, r.err);
                    chk("max_err", max_err, r.mx);
                    chk("pass", pass, r.ps);
                    chk("timeout", timeout, r.tmo);
                end
            end
            done_d = (done === 1'b1);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_mems();
        for (int i = 0; i < NS; i++) begin
            samp_mem[i] = DW'(i * 40503 + 17);
            ref_mem[i]  = samp_mem[i];
        end
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (done !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) chk("done_wait", done, 1);
    endtask

    // Starts a run, idles in ARM, then feeds nsamp back-to-back samples.
    task automatic run(input int nsamp, input bit arm_valid,
                       input bit drop_stable, input bit start_mid,
                       input bit timed_out, input res_t exp);
        res_q.push_back(exp);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 15; c++) begin
            ifc.data_in_valid = arm_valid && c >= 3 && c < 13;
            ifc.data_in       = DW'(24'hABCDE0 + c);
            tick();
        end
        ifc.data_in_valid = 1'b0;
        stable_in = 1'b1;
        tick();
        for (int i = 0; i < nsamp; i++) begin
            ifc.data_in       = samp_mem[i];
            ifc.data_in_valid = 1'b1;
            wr_q.push_back('{addr: AW'(i), data: samp_mem[i]});
            if (drop_stable && i == 50) stable_in = 1'b0;
            start = start_mid && i == 1000;
            tick();
        end
        ifc.data_in_valid = 1'b0;
        start = 1'b0;
        if (!timed_out) begin
            @(negedge clk);
            chk("done_early", done, 0);
            tick();
            @(negedge clk);
            chk("done_latency", done, 1);
            chk("busy_after", busy, 0);
        end else begin
            wait_done(TMO + 1000);
        end
        chk("wr_left", wr_q.size(), 0);
        stable_in = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        fork
            monitor();
        join_none

        rst = 1'b1;
        start = 1'b1;
        stable_in = 1'b0;
        ifc.data_in = '0;
        ifc.data_in_valid = 1'b0;
        load_mems();
        repeat (3) tick();
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_max", max_err, 0);
        chk("rst_pass", pass, 0);
        chk("rst_ref_addr", ifc.ref_addr, 0);
        tick();

        // Clean run, with a stray start mid-capture that must be ignored.
        run(NS, 0, 0, 1, 0, '{err: 0, mx: 0, ps: 1, tmo: 0});

        // Two injected mismatches: |−3| and |+7|.
        load_mems();
        ref_mem[5]   = ref_mem[5] + 24'd3;
        ref_mem[100] = ref_mem[100] - 24'd7;
        run(NS, 0, 0, 0, 0, '{err: 2, mx: 7, ps: 0, tmo: 0});

        // Full-scale opposite-sign difference.
        load_mems();
        samp_mem[0] = 24'h7FFFFF;
        ref_mem[0]  = 24'h800000;
        run(NS, 0, 0, 0, 0, '{err: 1, mx: 25'hFFFFFF, ps: 0, tmo: 0});

        // Valid samples in ARM are dropped; stable falling mid-capture.
        load_mems();
        run(NS, 1, 1, 0, 0, '{err: 0, mx: 0, ps: 1, tmo: 0});

        // Starved stream ends in timeout with only 100 samples checked.
        load_mems();
        ref_mem[5] = ref_mem[5] + 24'd3;
        run(100, 0, 0, 0, 1, '{err: 1, mx: 3, ps: 0, tmo: 1});

        // Reset in the middle of capture, then a clean rerun.
        load_mems();
        ref_mem[5] = ref_mem[5] + 24'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        stable_in = 1'b1;
        tick();
        for (int i = 0; i < 300; i++) begin
            ifc.data_in       = samp_mem[i];
            ifc.data_in_valid = 1'b1;
            wr_q.push_back('{addr: AW'(i), data: samp_mem[i]});
            tick();
        end
        ifc.data_in_valid = 1'b0;
        stable_in = 1'b0;
        tick();
        @(negedge clk);
        chk("pre_rst_err", err_cnt, 1);
        chk("pre_rst_busy", busy, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_err", err_cnt, 0);
        chk("mid_rst_max", max_err, 0);
        chk("mid_rst_tmo", timeout, 0);
        chk("mid_rst_wr_en", ifc.wr_en, 0);
        tick();
        load_mems();
        run(NS, 0, 0, 0, 0, '{err: 0, mx: 0, ps: 1, tmo: 0});

        chk("res_left", res_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
